// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV64 core.
// Chooses one action per cycle (RUN / LU_STALL / FLUSH / MEM_WAIT), drives the
// pipeline register enables and flushes, and keeps saturating performance
// counters plus a sticky data-memory timeout flag.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_id_inst,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } action_e;

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    action_e          state_q, action_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic [15:0]      timer_q;
    logic             err_q;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, lu;

    // Only opcode and source fields matter for hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{if_id_inst[31:25], if_id_inst[14:7]};

    assign opcode = if_id_inst[6:0];
    assign rs1    = if_id_inst[19:15];
    assign rs2    = if_id_inst[24:20];

    // Source-register usage decode and load-use hazard detection.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (opcode)
            7'b0000011, 7'b0010011: uses_rs1 = 1'b1;
            7'b0100011, 7'b0110011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
        lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
             ((uses_rs1 && (rs1 == id_ex_rd)) || (uses_rs2 && (rs2 == id_ex_rd)));
    end

    // Priority action select and pipeline control outputs.
    always_comb begin
        action_d    = RUN;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_hold = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (dmem_busy) begin
            // A taken branch waits in EX and is re-presented once memory is ready.
            action_d    = MEM_WAIT;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else if (ex_branch_taken) begin
            action_d    = FLUSH;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu) begin
            action_d    = LU_STALL;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Action register, saturating counters, busy timer and sticky timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= action_d;
            if ((action_d == LU_STALL || action_d == MEM_WAIT) && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (action_d == FLUSH && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
            if (dmem_busy) begin
                if (timer_q != '1)
                    timer_q <= timer_q + 16'(1);
                // Timer holds the count of earlier busy cycles, so equality
                // flags the cycle that pushes the wait past TIMEOUT.
                if (timer_q == TIMEOUT_V)
                    err_q <= 1'b1;
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign ctrl_state      = state_q;
    assign stall_cycles    = stall_q;
    assign flush_events    = flush_q;
    assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      if_id_inst;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic             ex_branch_taken;
    logic             dmem_busy;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic             mem_timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_id_inst      (if_id_inst),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_hold     (ex_mem_hold),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0, m_stall = 0, m_flush = 0, m_run = 0;
    bit m_err = 0;

    function automatic int model_action(input logic rst, input logic [31:0] inst,
                                        input logic mr, input logic [4:0] rd,
                                        input logic br, input logic busy);
        logic [6:0] op;
        bit u1, u2, hz;
        op = inst[6:0];
        u1 = (op == 7'h03) || (op == 7'h13) || (op == 7'h23) || (op == 7'h33) || (op == 7'h63);
        u2 = (op == 7'h23) || (op == 7'h33) || (op == 7'h63);
        hz = mr && rd != 0 && ((u1 && inst[19:15] == rd) || (u2 && inst[24:20] == rd));
        if (rst)       return -1;
        else if (busy) return 3;
        else if (br)   return 2;
        else if (hz)   return 1;
        else           return 0;
    endfunction

    // Compare every cycle on the falling edge, then advance the model by the
    // effect of the coming rising edge.
    always @(negedge clk) begin
        int a;
        a = model_action(reset, if_id_inst, id_ex_mem_read, id_ex_rd, ex_branch_taken, dmem_busy);
        chk("pc_write",    pc_write,    (a == 0 || a == 2));
        chk("if_id_write", if_id_write, (a == 0 || a == 2));
        chk("if_id_flush", if_id_flush, (a == -1 || a == 2));
        chk("id_ex_flush", id_ex_flush, (a == -1 || a == 1 || a == 2));
        chk("ex_mem_hold", ex_mem_hold, (a == 3));
        chk("ctrl_state",  ctrl_state,  m_state);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_events", flush_events, m_flush);
        chk("mem_timeout_err", mem_timeout_err, m_err);
        if (reset) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
        end else begin
            m_state = a;
            if ((a == 1 || a == 3) && m_stall < CMAX) m_stall++;
            if (a == 2 && m_flush < CMAX) m_flush++;
            m_run = dmem_busy ? m_run + 1 : 0;
            if (m_run > TIMEOUT) m_err = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rst, input logic [31:0] inst, input logic mr,
                         input logic [4:0] rd, input logic br, input logic busy);
        reset = rst; if_id_inst = inst; id_ex_mem_read = mr;
        id_ex_rd = rd; ex_branch_taken = br; dmem_busy = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_X6_X5_X5 = 32'h00528333;
    localparam logic [31:0] SD_RS2_7     = 32'h00733023;
    localparam logic [31:0] NOP          = 32'h00000013;

    logic [6:0] ops [8] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h37, 7'h6F, 7'h73};

    initial begin
        drive(1, NOP, 0, 0, 0, 0);
        tick(); tick();
        #1;
        chk("rst_if_id_flush", if_id_flush, 1);
        chk("rst_id_ex_flush", id_ex_flush, 1);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_ex_mem_hold", ex_mem_hold, 0);
        drive(0, NOP, 0, 0, 0, 0);
        #1;
        chk("reset_state", ctrl_state, 0);
        chk("reset_stall", stall_cycles, 0);
        chk("reset_flush", flush_events, 0);
        chk("reset_err", mem_timeout_err, 0);
        tick();

        // Load-use on rs1
        drive(0, ADD_X6_X5_X5, 1, 5, 0, 0);
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        chk("lu_id_ex_flush", id_ex_flush, 1);
        tick();
        chk("lu_state", ctrl_state, 1);
        chk("lu_stall", stall_cycles, 1);
        drive(0, ADD_X6_X5_X5, 1, 0, 0, 0);
        #1;
        chk("rd0_pc_write", pc_write, 1);
        tick();
        chk("rd0_state", ctrl_state, 0);

        // Store data dependency through rs2
        drive(0, SD_RS2_7, 1, 7, 0, 0);
        #1;
        chk("sd_pc_write", pc_write, 0);
        tick();
        chk("sd_state", ctrl_state, 1);
        chk("sd_stall", stall_cycles, 2);
        drive(0, SD_RS2_7, 0, 7, 0, 0);
        #1;
        chk("sd_nolu_pc_write", pc_write, 1);
        tick();
        chk("sd_nolu_stall", stall_cycles, 2);

        // Branch overrides load-use
        drive(0, ADD_X6_X5_X5, 1, 5, 1, 0);
        #1;
        chk("br_if_id_flush", if_id_flush, 1);
        chk("br_id_ex_flush", id_ex_flush, 1);
        chk("br_pc_write", pc_write, 1);
        tick();
        chk("br_flush_cnt", flush_events, 1);
        chk("br_stall_cnt", stall_cycles, 2);

        // Memory wait holds a taken branch for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, NOP, 0, 0, 1, 1);
            #1;
            chk("mw_hold", ex_mem_hold, 1);
            chk("mw_pc_write", pc_write, 0);
            chk("mw_flush", if_id_flush | id_ex_flush, 0);
            tick();
        end
        chk("mw_stall_cnt", stall_cycles, 5);
        chk("mw_state", ctrl_state, 3);
        drive(0, NOP, 0, 0, 1, 0);
        #1;
        chk("mw_then_flush", if_id_flush, 1);
        tick();
        chk("mw_flush_cnt", flush_events, 2);

        // Timeout with TIMEOUT=4
        drive(1, NOP, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive(0, NOP, 0, 0, 0, 1);
            tick();
            chk("to_err", mem_timeout_err, (i >= 5));
        end
        drive(0, NOP, 0, 0, 0, 0);
        tick();
        chk("to_sticky", mem_timeout_err, 1);
        chk("to_stall_cnt", stall_cycles, 6);

        // Flush counter saturation
        for (int i = 0; i < 10; i++) begin
            drive(0, NOP, 0, 0, 1, 0);
            tick();
        end
        chk("sat_flush", flush_events, 7);

        // Reset in the middle of a memory wait
        drive(0, NOP, 0, 0, 0, 1);
        tick(); tick();
        drive(1, NOP, 0, 0, 0, 1);
        #1;
        chk("mrst_if_id_flush", if_id_flush, 1);
        chk("mrst_id_ex_flush", id_ex_flush, 1);
        chk("mrst_hold", ex_mem_hold, 0);
        tick();
        drive(0, NOP, 0, 0, 0, 0);
        #1;
        chk("mrst_state", ctrl_state, 0);
        chk("mrst_stall", stall_cycles, 0);
        chk("mrst_flush", flush_events, 0);
        chk("mrst_err", mem_timeout_err, 1'b0);
        tick();

        // Randomized traffic, model checked every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            inst[6:0]   = ops[$urandom_range(0, 7)];
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 99) == 0), inst, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                  (i % 200 < 12) ? 1'b1 : ($urandom_range(0, 4) == 0));
            tick();
        end

        drive(0, NOP, 0, 0, 0, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
